sd_cmd_seq: RTL and testbench
=============================

Name: sd_cmd_seq

Overview:
- Command sequencer that drives the byte-level SPI master handshake to issue SD-card SPI-mode commands.
- Generates the power-up dummy clock train (CS high) or a full command frame: 6 command bytes, R1 polling, then one trailing byte with CS high.
- Sits between a host/boot controller and the SPI master; it is the only user of the SPI master and owns the card chip select.

Parameters:
- DUMMY_BYTES, 10, number of 0xFF bytes sent with CS high in dummy mode (80 clocks).
- RESP_POLLS, 8, maximum 0xFF poll bytes sent while waiting for R1 (range 1..255).

Ports:
- iClk  in  1  system clock (10 MHz domain).
- iRst  in  1  synchronous reset, active-high.
- iStart  in  1  one-cycle request; sampled only in IDLE.
- iDummy  in  1  sampled with iStart: 1 = dummy-clock mode, 0 = command mode.
- iCmd  in  6  command index.
- iArg  in  32  command argument, MSB first.
- iCrc  in  7  CRC7 for byte 6; ignored when SD_CMD_CRC7_EN is defined.
- oBusy  out  1  high from accepted start until oDone.
- oDone  out  1  one-cycle completion pulse.
- oTimeout  out  1  valid with oDone: no R1 within RESP_POLLS.
- oR1  out  8  R1 response byte; valid from oDone until the next start.
- oCs  out  1  card chip select, active-low.
- oSpiSend  out  1  byte request to the SPI master.
- oSpiData  out  8  byte to transmit.
- iSpiRx  in  8  received byte.
- iSpiAvail  in  1  received-byte strobe.
- iSpiTaken  in  1  SPI master accepted oSpiSend.

Behaviour:
- Reset values: oCs=1, oSpiSend=0, oSpiData=0xFF, oBusy=0, oDone=0, oTimeout=0, oR1=0xFF; state IDLE.
- Reset has priority in any state. A mid-transfer reset drops oSpiSend and raises oCs in the next cycle. The in-flight SPI byte completes and its iSpiAvail is ignored.
- Byte handshake (one byte in flight at a time):
  - Register oSpiData, set oSpiSend=1 and hold both stable.
  - On iSpiTaken, clear oSpiSend on the next edge.
  - Wait for iSpiAvail and latch iSpiRx.
  - If iSpiTaken and iSpiAvail occur together, treat taken first, then avail.
- States:
  - IDLE: on iStart, latch iCmd/iArg/iCrc/iDummy and set oBusy. Go to DUMMY if iDummy=1, else to SELECT.
  - DUMMY: send DUMMY_BYTES x 0xFF with oCs=1, then go to FINISH.
  - SELECT: set oCs=0 for one cycle, then go to TX.
  - TX: send bytes in order:
    - {2'b01, cmd}
    - arg[31:24], arg[23:16], arg[15:8], arg[7:0]
    - {crc7, 1'b1}
    - The 3-bit byte index wraps 0..5.
  - POLL: send 0xFF and count polls.
    - If the received byte has bit7=0: oR1 = that byte, go to TRAIL.
    - If the count reaches RESP_POLLS with no match: oR1=0xFF, oTimeout=1, go to TRAIL.
  - TRAIL: set oCs=1, send one 0xFF, then go to FINISH.
  - FINISH: pulse oDone, clear oBusy, return to IDLE.
- oTimeout is held until the next accepted start.
- Dummy mode leaves oR1 unchanged and sets oTimeout=0.
- iStart while oBusy=1 is ignored; there is no queueing.
- Latency from iStart to the first oSpiSend: 2 cycles (DUMMY path) or 3 cycles (SELECT path).

Optional Feature:
- Macro: SD_CMD_CRC7_EN.
- Defined: byte 6 = {crc7, 1}. The CRC is computed over bytes 1-5 with polynomial x^7+x^3+1, init 0, bitwise MSB first. It is computed combinationally from the latched command and argument. iCrc is unused.
- Undefined: byte 6 = {iCrc latched, 1}, and the CRC logic is absent.

Decomposition:
- Shared package/header sd_pkg.vh:
  - state encodings;
  - SD_FILL = 8'hFF;
  - start bits 2'b01;
  - command constants CMD0, CMD8, CMD55, ACMD41, CMD17, CMD24.
- One sub-module, sd_crc7: 40-bit input, 7-bit output, combinational. It is instantiated only under SD_CMD_CRC7_EN.

Test Plan:
- CMD0 with arg=0, iCrc=7'h4A (macro on or off). Required SPI bytes: 40 00 00 00 00 95. Card returns FF FF 01, so after the 6 command bytes 3 polls are sent. Required: oR1=01, oTimeout=0, one trailing FF with oCs=1, then oDone.
- CMD8 with arg=0x000001AA and the macro defined. Required byte 6 = 0x87. Card returns 01 on the first poll. Required: exactly one poll, then TRAIL.
- Command with the card always returning FF and RESP_POLLS=8. Required: exactly 8 polls, oTimeout=1, oR1=FF, oCs high before the trailing byte.
- iDummy=1 start. Required: 10 x FF sent, oCs stays 1 throughout, oDone after the 10th iSpiAvail, oR1 unchanged.
- Assert iStart again during TX. Required: ignored, and the byte stream is unchanged.
- Assert iRst during the 3rd TX byte. Required: next cycle oSpiSend=0, oCs=1, oBusy=0. A subsequent CMD0 completes correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI-mode command sequencer.
`timescale 1ns/1ps
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DUMMY  = 3'd1,
    ST_SELECT = 3'd2,
    ST_TX     = 3'd3,
    ST_POLL   = 3'd4,
    ST_TRAIL  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  // Per-byte handshake phase inside the byte-sending states.
  typedef enum logic [1:0] {
    PH_LOAD = 2'd0,
    PH_SEND = 2'd1,
    PH_WAIT = 2'd2
  } phase_t;

  localparam logic [7:0] SD_FILL  = 8'hFF;
  localparam logic [1:0] SD_START = 2'b01;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD17  = 6'd17;
  localparam logic [5:0] CMD24  = 6'd24;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] ACMD41 = 6'd41;

endpackage

// File: rtl/sd_crc7.sv
// CRC7 (x^7 + x^3 + 1, init 0, MSB first) over the first five command bytes.
`timescale 1ns/1ps
module sd_crc7 (
  input  logic [39:0] data,
  output logic [6:0]  crc
);

  always_comb begin
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      c = {c[5:0], 1'b0} ^ ((data[i] ^ c[6]) ? 7'h09 : 7'h00);
    end
    crc = c;
  end

endmodule

// File: rtl/sd_cmd_seq.sv
// SD SPI-mode command sequencer: dummy clock train or command/R1-poll/trailer frame.
// Build option SD_CMD_CRC7_EN computes byte 6 internally instead of using iCrc.
`timescale 1ns/1ps
module sd_cmd_seq
  import sd_pkg::*;
#(
  parameter int DUMMY_BYTES = 10,
  parameter int RESP_POLLS  = 8
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iDummy,
  input  logic [5:0]  iCmd,
  input  logic [31:0] iArg,
  input  logic [6:0]  iCrc,
  output logic        oBusy,
  output logic        oDone,
  output logic        oTimeout,
  output logic [7:0]  oR1,
  output logic        oCs,
  output logic        oSpiSend,
  output logic [7:0]  oSpiData,
  input  logic [7:0]  iSpiRx,
  input  logic        iSpiAvail,
  input  logic        iSpiTaken,
  output logic [2:0]  oState
);

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_BYTES - 1);
  localparam logic [7:0] POLL_LAST  = 8'(RESP_POLLS - 1);

  state_t      state;
  phase_t      phase;
  logic [2:0]  idx;
  logic [7:0]  cnt;
  logic [5:0]  cmd_q;
  logic [31:0] arg_q;
  logic [6:0]  crc_byte;
  logic [7:0]  tx_byte;
  logic        byte_state;
  logic        byte_done;

`ifdef SD_CMD_CRC7_EN
  logic unused_crc;
  assign unused_crc = ^iCrc;
  sd_crc7 u_crc (
    .data ({SD_START, cmd_q, arg_q}),
    .crc  (crc_byte)
  );
`else
  logic [6:0] crc_q;
  assign crc_byte = crc_q;
`endif

  assign oState = state;

  always_comb begin
    tx_byte = SD_FILL;
    case (idx)
      3'd0:    tx_byte = {SD_START, cmd_q};
      3'd1:    tx_byte = arg_q[31:24];
      3'd2:    tx_byte = arg_q[23:16];
      3'd3:    tx_byte = arg_q[15:8];
      3'd4:    tx_byte = arg_q[7:0];
      3'd5:    tx_byte = {crc_byte, 1'b1};
      default: tx_byte = SD_FILL;
    endcase
  end

  // Handshake: oSpiSend/oSpiData are held until iSpiTaken; the byte is complete
  // on iSpiAvail. Taken and avail in the same cycle count as taken-then-avail.
  assign byte_state = (state == ST_DUMMY) || (state == ST_TX) ||
                      (state == ST_POLL)  || (state == ST_TRAIL);
  assign byte_done  = byte_state &&
                      (((phase == PH_SEND) && iSpiTaken && iSpiAvail) ||
                       ((phase == PH_WAIT) && iSpiAvail));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= ST_IDLE;
      phase    <= PH_LOAD;
      idx      <= '0;
      cnt      <= '0;
      cmd_q    <= '0;
      arg_q    <= '0;
`ifndef SD_CMD_CRC7_EN
      crc_q    <= '0;
`endif
      oCs      <= 1'b1;
      oSpiSend <= 1'b0;
      oSpiData <= SD_FILL;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oTimeout <= 1'b0;
      oR1      <= SD_FILL;
    end else begin
      oDone <= 1'b0;

      if (byte_state) begin
        case (phase)
          PH_LOAD: begin
            oSpiData <= (state == ST_TX) ? tx_byte : SD_FILL;
            oSpiSend <= 1'b1;
            phase    <= PH_SEND;
          end
          PH_SEND: begin
            if (iSpiTaken) begin
              oSpiSend <= 1'b0;
              phase    <= iSpiAvail ? PH_LOAD : PH_WAIT;
            end
          end
          PH_WAIT: begin
            if (iSpiAvail) phase <= PH_LOAD;
          end
          default: phase <= PH_LOAD;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (iStart) begin
            cmd_q    <= iCmd;
            arg_q    <= iArg;
`ifndef SD_CMD_CRC7_EN
            crc_q    <= iCrc;
`endif
            oBusy    <= 1'b1;
            oTimeout <= 1'b0;
            phase    <= PH_LOAD;
            idx      <= '0;
            cnt      <= '0;
            state    <= iDummy ? ST_DUMMY : ST_SELECT;
          end
        end
        ST_DUMMY: begin
          if (byte_done) begin
            if (cnt == DUMMY_LAST) state <= ST_FINISH;
            else                   cnt   <= cnt + 8'd1;
          end
        end
        ST_SELECT: begin
          oCs   <= 1'b0;
          state <= ST_TX;
        end
        ST_TX: begin
          if (byte_done) begin
            if (idx == 3'd5) begin
              idx   <= '0;
              cnt   <= '0;
              state <= ST_POLL;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        ST_POLL: begin
          // Card is deselected before the trailing byte goes out.
          if (byte_done) begin
            if (!iSpiRx[7]) begin
              oR1   <= iSpiRx;
              oCs   <= 1'b1;
              state <= ST_TRAIL;
            end else if (cnt == POLL_LAST) begin
              oR1      <= SD_FILL;
              oTimeout <= 1'b1;
              oCs      <= 1'b1;
              state    <= ST_TRAIL;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_TRAIL: begin
          if (byte_done) state <= ST_FINISH;
        end
        ST_FINISH: begin
          oDone <= 1'b1;
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Bench for sd_cmd_seq: SPI slave/card model with random handshake timing,
// frame-level reference model, directed plus random transactions.
`timescale 1ns/1ps
module tb_sd_cmd_seq;
  import sd_pkg::*;

  localparam int DUMMY_BYTES = 10;
  localparam int RESP_POLLS  = 8;

  logic        iClk, iRst, iStart, iDummy;
  logic [5:0]  iCmd;
  logic [31:0] iArg;
  logic [6:0]  iCrc;
  logic        oBusy, oDone, oTimeout, oCs, oSpiSend;
  logic [7:0]  oR1, oSpiData, iSpiRx;
  logic        iSpiAvail, iSpiTaken;
  logic [2:0]  oState;

  sd_cmd_seq #(.DUMMY_BYTES(DUMMY_BYTES), .RESP_POLLS(RESP_POLLS)) dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart), .iDummy(iDummy),
    .iCmd(iCmd), .iArg(iArg), .iCrc(iCrc),
    .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout), .oR1(oR1),
    .oCs(oCs), .oSpiSend(oSpiSend), .oSpiData(oSpiData),
    .iSpiRx(iSpiRx), .iSpiAvail(iSpiAvail), .iSpiTaken(iSpiTaken),
    .oState(oState)
  );

  // ---------------- clock / reset ----------------
  initial iClk = 1'b0;
  always #50 iClk = ~iClk;

  // ---------------- shared bench state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [8:0]  cap_q[$];   // {cs, byte} as seen when the slave takes a byte
  logic [8:0]  exp_q[$];
  logic [7:0]  rx_q[$];    // bytes the slave returns, in order
  logic [7:0]  card_q[$];  // card answers to successive R1 polls
  logic [7:0]  model_r1;
  logic [7:0]  exp_r1;
  logic        exp_to;
  logic        slave_busy;
  int          cs_low_cnt;
  int          sd, sa;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_crc(input logic [39:0] d);
    logic [46:0] v;
    v = {d, 7'b0};
    for (int i = 46; i >= 7; i--) if (v[i]) v = v ^ (47'h89 << (i - 7));
    return v[6:0];
  endfunction

  always @(negedge iClk) if (!oCs) cs_low_cnt++;

  // ---------------- SPI master + card model ----------------
  initial begin
    iSpiTaken  = 1'b0;
    iSpiAvail  = 1'b0;
    iSpiRx     = 8'hFF;
    slave_busy = 1'b0;
    forever begin
      @(negedge iClk);
      if (oSpiSend) begin
        slave_busy = 1'b1;
        sd = $urandom_range(0, 2);
        repeat (sd) @(negedge iClk);
        cap_q.push_back({oCs, oSpiData});
        iSpiTaken = 1'b1;
        sa = $urandom_range(0, 3);
        if (sa == 0) begin
          iSpiRx    = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
          iSpiAvail = 1'b1;
        end
        @(negedge iClk);
        iSpiTaken = 1'b0;
        iSpiAvail = 1'b0;
        if (sa != 0) begin
          repeat (sa - 1) @(negedge iClk);
          iSpiRx    = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
          iSpiAvail = 1'b1;
          @(negedge iClk);
          iSpiAvail = 1'b0;
        end
        slave_busy = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic build_model(input bit dummy, input logic [5:0] cmd,
                             input logic [31:0] arg, input logic [6:0] crc);
    logic [39:0] frame;
    logic [7:0]  r;
    exp_q.delete();
    if (dummy) begin
      repeat (DUMMY_BYTES) exp_q.push_back({1'b1, 8'hFF});
      exp_r1 = model_r1;
      exp_to = 1'b0;
    end else begin
      frame = {2'b01, cmd, arg};
      for (int b = 0; b < 5; b++) exp_q.push_back({1'b0, frame[39-8*b -: 8]});
`ifdef SD_CMD_CRC7_EN
      exp_q.push_back({1'b0, ref_crc(frame), 1'b1});
`else
      exp_q.push_back({1'b0, crc, 1'b1});
`endif
      exp_r1 = 8'hFF;
      exp_to = 1'b1;
      for (int k = 0; k < RESP_POLLS; k++) begin
        r = (k < card_q.size()) ? card_q[k] : 8'hFF;
        exp_q.push_back({1'b0, 8'hFF});
        if (!r[7]) begin
          exp_r1 = r;
          exp_to = 1'b0;
          break;
        end
      end
      exp_q.push_back({1'b1, 8'hFF});
    end
    model_r1 = exp_r1;
  endtask

  // ---------------- driver ----------------
  task automatic drive_start(input bit dummy, input logic [5:0] cmd,
                             input logic [31:0] arg, input logic [6:0] crc);
    rx_q.delete();
    if (!dummy) begin
      repeat (6) rx_q.push_back(8'hFF);
      foreach (card_q[i]) rx_q.push_back(card_q[i]);
    end
    cap_q.delete();
    cs_low_cnt = 0;
    @(negedge iClk);
    iStart = 1'b1; iDummy = dummy; iCmd = cmd; iArg = arg; iCrc = crc;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  task automatic run_txn(input string name, input bit dummy, input logic [5:0] cmd,
                         input logic [31:0] arg, input logic [6:0] crc, input bit poke);
    int lat, cyc, n;
    build_model(dummy, cmd, arg, crc);
    drive_start(dummy, cmd, arg, crc);
    check({name, ".busy"}, oBusy, 1'b1);
    lat = 1;
    while (!oSpiSend && lat < 20) begin
      @(negedge iClk);
      lat++;
    end
    check({name, ".latency"}, lat, dummy ? 2 : 3);
    cyc = 0;
    while (!oDone && cyc < 3000) begin
      @(negedge iClk);
      cyc++;
      if (poke && cyc == 12) begin
        iStart = 1'b1; iDummy = 1'b1; iCmd = 6'($urandom); iArg = $urandom;
      end else begin
        iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    check({name, ".done"}, oDone, 1'b1);
    check({name, ".r1"}, oR1, exp_r1);
    check({name, ".timeout"}, oTimeout, exp_to);
    check({name, ".busy_end"}, oBusy, 1'b0);
    if (dummy) check({name, ".cs_low"}, cs_low_cnt, 0);
    check({name, ".nbytes"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.byte%0d", name, i), cap_q[i], exp_q[i]);
    @(negedge iClk);
    check({name, ".done_pulse"}, oDone, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc, lead;
    logic [7:0] b;
    iRst = 1'b1; iStart = 1'b0; iDummy = 1'b0; iCmd = '0; iArg = '0; iCrc = '0;
    model_r1 = 8'hFF;
    repeat (3) @(negedge iClk);
    check("rst.cs", oCs, 1'b1);
    check("rst.send", oSpiSend, 1'b0);
    check("rst.data", oSpiData, 8'hFF);
    check("rst.busy", oBusy, 1'b0);
    check("rst.done", oDone, 1'b0);
    check("rst.timeout", oTimeout, 1'b0);
    check("rst.r1", oR1, 8'hFF);
    check("rst.state", oState, 3'(ST_IDLE));
    iRst = 1'b0;
    repeat (2) @(negedge iClk);

    card_q = '{8'hFF, 8'hFF, 8'h01};
    run_txn("cmd0", 1'b0, CMD0, 32'h0, 7'h4A, 1'b0);
    check("cmd0.crc_byte", cap_q.size() > 5 ? cap_q[5][7:0] : 8'h00, 8'h95);

    card_q = '{8'h01};
    run_txn("cmd8", 1'b0, CMD8, 32'h0000_01AA, 7'h43, 1'b0);
    check("cmd8.crc_byte", cap_q.size() > 5 ? cap_q[5][7:0] : 8'h00, 8'h87);

    card_q.delete();
    run_txn("tmo", 1'b0, CMD55, 32'h0, 7'h32, 1'b0);

    card_q.delete();
    run_txn("dummy", 1'b1, 6'd0, 32'h0, 7'h0, 1'b0);

    card_q = '{8'hFF, 8'h00};
    run_txn("poke", 1'b0, CMD17, 32'h1234_5678, 7'h2A, 1'b1);

    // Reset in the middle of the command bytes.
    card_q = '{8'h01};
    drive_start(1'b0, CMD24, 32'hDEAD_BEEF, 7'h11);
    cyc = 0;
    while (!(cap_q.size() >= 2 && cap_q.size() <= 4 && oSpiSend) && cyc < 200) begin
      @(negedge iClk);
      cyc++;
    end
    check("mid_rst.reached", cyc < 200, 1'b1);
    iRst = 1'b1;
    @(negedge iClk);
    check("mid_rst.send", oSpiSend, 1'b0);
    check("mid_rst.cs", oCs, 1'b1);
    check("mid_rst.busy", oBusy, 1'b0);
    iRst = 1'b0;
    model_r1 = 8'hFF;
    cyc = 0;
    repeat (2) @(negedge iClk);
    while (slave_busy && cyc < 50) begin
      @(negedge iClk);
      cyc++;
    end
    repeat (2) @(negedge iClk);
    card_q = '{8'hFF, 8'hFF, 8'h01};
    run_txn("cmd0_after_rst", 1'b0, CMD0, 32'h0, 7'h4A, 1'b0);

    // Random commands, random card latency (some past the poll limit).
    for (int t = 0; t < 16; t++) begin
      card_q.delete();
      lead = $urandom_range(0, 10);
      for (int k = 0; k < lead; k++) begin
        b = 8'($urandom) | 8'h80;
        card_q.push_back(b);
      end
      b = 8'($urandom) & 8'h7F;
      card_q.push_back(b);
      run_txn($sformatf("rnd%0d", t), ($urandom_range(0, 4) == 0), 6'($urandom),
              $urandom, 7'($urandom), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
